// File: rtl/frame_sequencer.sv
// Per-frame controller: latches geometry, handshakes the pipeline frame reset,
// streams raster pixels with stall back-pressure, then waits for end-of-frame.
module frame_sequencer #(
    parameter int COORD_BITS    = 11,
    parameter int LUMA_BITS     = 8,
    parameter int COUNT_BITS    = 16,
    parameter int FLUSH_TIMEOUT = 65535,
    parameter int MIN_DIM       = 37
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_BITS-1:0] r_width,
    input  logic [COORD_BITS-1:0] r_height,
    input  logic                  r_start,
    input  logic                  r_abort,
    input  logic                  src_valid,
    input  logic [LUMA_BITS-1:0]  src_pixel,
    output logic                  src_ready,
    output logic                  pipe_begin_frame_reset,
    input  logic                  pipe_frame_reset_complete,
    output logic                  pipe_valid,
    output logic [LUMA_BITS-1:0]  pipe_pixel,
    output logic [COORD_BITS-1:0] pipe_x,
    output logic [COORD_BITS-1:0] pipe_y,
    input  logic                  pipe_request_stall,
    input  logic                  pipe_corner_count_increment,
    input  logic                  pipe_frame_end,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_error,
    output logic [COUNT_BITS-1:0] out_corner_count,
    output logic [15:0]           out_frame_count
);

    localparam int FT_BITS = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [COORD_BITS-1:0] MIN_DIM_C  = COORD_BITS'(MIN_DIM);
    localparam logic [COORD_BITS-1:0] ONE_C      = COORD_BITS'(1);
    localparam logic [FT_BITS-1:0]    FLUSH_LAST = FT_BITS'(FLUSH_TIMEOUT - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX  = {COUNT_BITS{1'b1}};

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESET_REQ  = 3'd1,
        WAIT_RESET = 3'd2,
        STREAM     = 3'd3,
        FLUSH      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [COORD_BITS-1:0]   width_q, width_d, height_q, height_d;
    logic [COORD_BITS-1:0]   x_q, x_d, y_q, y_d;
    logic [FT_BITS-1:0]      flush_q, flush_d;
    logic                    error_q, error_d, done_q, done_d;
    logic [COUNT_BITS-1:0]   corner_q, corner_d;
    logic [15:0]             frame_q, frame_d;
    logic                    transfer_s, counting_s;

    assign src_ready              = (state_q == STREAM) && !pipe_request_stall;
    assign pipe_valid             = src_valid && src_ready;
    assign pipe_pixel             = src_pixel;
    assign transfer_s             = pipe_valid;
    assign pipe_x                 = x_q;
    assign pipe_y                 = y_q;
    assign pipe_begin_frame_reset = (state_q == RESET_REQ);
    assign out_busy               = (state_q != IDLE);
    assign out_done               = done_q;
    assign out_error              = error_q;
    assign out_corner_count       = corner_q;
    assign out_frame_count        = frame_q;
    assign counting_s = (state_q == WAIT_RESET) || (state_q == STREAM) || (state_q == FLUSH);

    // Next-state, counters and status; abort is applied last so it overrides everything.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        x_d      = x_q;
        y_d      = y_q;
        flush_d  = flush_q;
        error_d  = error_q;
        done_d   = 1'b0;
        corner_d = corner_q;
        frame_d  = frame_q;

        if (counting_s && pipe_corner_count_increment && (corner_q != COUNT_MAX)) begin
            corner_d = corner_q + COUNT_BITS'(1);
        end else begin
            corner_d = corner_q;
        end

        case (state_q)
            IDLE: begin
                if (r_start && !r_abort) begin
                    if ((r_width < MIN_DIM_C) || (r_height < MIN_DIM_C)) begin
                        error_d = 1'b1;
                    end else begin
                        width_d  = r_width;
                        height_d = r_height;
                        error_d  = 1'b0;
                        corner_d = {COUNT_BITS{1'b0}};
                        flush_d  = {FT_BITS{1'b0}};
                        state_d  = RESET_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESET_REQ: begin
                x_d = {COORD_BITS{1'b0}};
                y_d = {COORD_BITS{1'b0}};
                if (pipe_frame_reset_complete) begin
                    state_d = STREAM;
                end else begin
                    state_d = WAIT_RESET;
                end
            end
            WAIT_RESET: begin
                if (pipe_frame_reset_complete) begin
                    state_d = STREAM;
                    x_d     = {COORD_BITS{1'b0}};
                    y_d     = {COORD_BITS{1'b0}};
                end else begin
                    state_d = WAIT_RESET;
                end
            end
            STREAM: begin
                if (transfer_s) begin
                    if (x_q == width_q - ONE_C) begin
                        x_d = {COORD_BITS{1'b0}};
                        if (y_q == height_q - ONE_C) begin
                            y_d     = {COORD_BITS{1'b0}};
                            flush_d = {FT_BITS{1'b0}};
                            state_d = FLUSH;
                        end else begin
                            y_d = y_q + ONE_C;
                        end
                    end else begin
                        x_d = x_q + ONE_C;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            FLUSH: begin
                if (pipe_frame_end) begin
                    done_d  = 1'b1;
                    frame_d = frame_q + 16'd1;
                    state_d = IDLE;
                end else if (flush_q == FLUSH_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    flush_d = flush_q + FT_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (r_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
            frame_d = frame_q;
            error_d = error_q;
            x_d     = {COORD_BITS{1'b0}};
            y_d     = {COORD_BITS{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            width_q  <= {COORD_BITS{1'b0}};
            height_q <= {COORD_BITS{1'b0}};
            x_q      <= {COORD_BITS{1'b0}};
            y_q      <= {COORD_BITS{1'b0}};
            flush_q  <= {FT_BITS{1'b0}};
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            corner_q <= {COUNT_BITS{1'b0}};
            frame_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            x_q      <= x_d;
            y_q      <= y_d;
            flush_q  <= flush_d;
            error_q  <= error_d;
            done_q   <= done_d;
            corner_q <= corner_d;
            frame_q  <= frame_d;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: raster model of expected pixels/coordinates
// and frame completions, checked by an independent output monitor.
module tb_frame_sequencer;

    localparam int CB   = 3;
    localparam int FT   = 50;
    localparam int CMAX = (1 << CB) - 1;

    logic        clk = 1'b0;
    logic        reset, r_start, r_abort, src_valid, ack, stall, inc, fend;
    logic [10:0] r_width, r_height;
    logic [7:0]  src_pixel;
    logic        src_ready, begin_rst, pipe_valid, out_busy, out_done, out_error;
    logic [7:0]  pipe_pixel;
    logic [10:0] pipe_x, pipe_y;
    logic [CB-1:0] out_cc;
    logic [15:0] out_fc;

    typedef struct { logic [7:0] p; logic [10:0] x; logic [10:0] y; } px_t;
    typedef struct { int fc; int cc; } done_t;
    px_t   exp_px[$];
    done_t exp_done[$];

    int checks = 0, failures = 0;
    int exp_cc = 0, exp_fc = 0;

    frame_sequencer #(.COORD_BITS(11), .LUMA_BITS(8), .COUNT_BITS(CB),
                      .FLUSH_TIMEOUT(FT), .MIN_DIM(37)) dut (
        .clk(clk), .reset(reset), .r_width(r_width), .r_height(r_height),
        .r_start(r_start), .r_abort(r_abort), .src_valid(src_valid),
        .src_pixel(src_pixel), .src_ready(src_ready),
        .pipe_begin_frame_reset(begin_rst),
        .pipe_frame_reset_complete(ack), .pipe_valid(pipe_valid),
        .pipe_pixel(pipe_pixel), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .pipe_request_stall(stall), .pipe_corner_count_increment(inc),
        .pipe_frame_end(fend), .out_busy(out_busy), .out_done(out_done),
        .out_error(out_error), .out_corner_count(out_cc),
        .out_frame_count(out_fc));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic push_px(input logic [7:0] p, input int idx, input int w);
        px_t e;
        e.p = p;
        e.x = 11'(idx % w);
        e.y = 11'(idx / w);
        exp_px.push_back(e);
    endtask

    // Monitor: compares every pipeline strobe and every done pulse against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b0) begin
            if (pipe_valid === 1'b1) begin
                if (exp_px.size() == 0) begin
                    check("pix_unexpected", 32'd1, 32'd0);
                end else begin
                    px_t e;
                    e = exp_px.pop_front();
                    check("pix_value", 32'(pipe_pixel), 32'(e.p));
                    check("pix_x", 32'(pipe_x), 32'(e.x));
                    check("pix_y", 32'(pipe_y), 32'(e.y));
                end
            end
            if (out_done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_frame_count", 32'(out_fc), 32'(d.fc));
                    check("done_corner_count", 32'(out_cc), 32'(d.cc));
                    check("done_busy_low", 32'(out_busy), 32'd0);
                end
            end
        end
    end

    // One frame: start, reset handshake, streaming, then frame_end / timeout / abort.
    task automatic run_frame(input int w, input int h, input bit ack_now, input int mode,
                             input int n_inc, input int fend_delay, input int abort_k);
        int k = 0, cyc = 0, ninc = 0;
        bit aborted = 1'b0;
        @(negedge clk);
        r_width = 11'(w); r_height = 11'(h); r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0; ack = ack_now;
        exp_cc = 0;
        #1;
        check("begin_reset", 32'(begin_rst), 32'd1);
        check("start_busy", 32'(out_busy), 32'd1);
        check("start_error_clr", 32'(out_error), 32'd0);
        check("start_cc_clr", 32'(out_cc), 32'd0);
        if (!ack_now) begin
            @(negedge clk); inc = 1'b1; exp_cc = sat_inc(exp_cc);
            #1 check("begin_one_cycle", 32'(begin_rst), 32'd0);
            @(negedge clk); inc = 1'b0;
            @(negedge clk); ack = 1'b1;
        end
        while (k < w * h && cyc < 20000) begin
            @(negedge clk);
            ack = 1'b0;
            stall = (mode == 0) ? 1'b0 : 1'(((cyc / 3) % 2) == 1);
            src_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            src_pixel = 8'($urandom);
            fend = (mode == 1 && cyc == 50) ? 1'b1 : 1'b0;
            inc = (ninc < n_inc && (cyc % 97) == 5) ? 1'b1 : 1'b0;
            if (inc) begin ninc++; exp_cc = sat_inc(exp_cc); end
            r_abort = (k == abort_k) ? 1'b1 : 1'b0;
            #1;
            check("src_ready_vs_stall", 32'(src_ready), 32'(!stall));
            if (src_valid && !stall) begin push_px(src_pixel, k, w); k++; end
            cyc++;
            if (r_abort) begin aborted = 1'b1; break; end
        end
        if (cyc >= 20000) check("stream_budget", 32'(cyc), 32'd0);
        @(negedge clk);
        src_valid = 1'b1; stall = 1'b0; inc = 1'b0; fend = 1'b0; r_abort = 1'b0;
        #1;
        if (aborted) begin
            check("abort_idle", 32'(out_busy), 32'd0);
            check("abort_cc_hold", 32'(out_cc), 32'(exp_cc));
            check("abort_fc_hold", 32'(out_fc), 32'(exp_fc));
            src_valid = 1'b0;
            return;
        end
        check("flush_busy", 32'(out_busy), 32'd1);
        check("flush_src_ready", 32'(src_ready), 32'd0);
        check("flush_pipe_valid", 32'(pipe_valid), 32'd0);
        if (fend_delay < 0) begin
            repeat (FT - 1) @(negedge clk);
            src_valid = 1'b0;
            #1 check("timeout_not_yet", 32'(out_busy), 32'd1);
            @(negedge clk);
            #1;
            check("timeout_idle", 32'(out_busy), 32'd0);
            check("timeout_error", 32'(out_error), 32'd1);
            check("timeout_fc_hold", 32'(out_fc), 32'(exp_fc));
            return;
        end
        repeat (fend_delay) @(negedge clk);
        src_valid = 1'b0;
        @(negedge clk);
        fend = 1'b1; inc = 1'b1;
        exp_cc = sat_inc(exp_cc); exp_fc++;
        exp_done.push_back('{fc: exp_fc, cc: exp_cc});
        #1 check("pre_done_busy", 32'(out_busy), 32'd1);
        @(negedge clk);
        fend = 1'b0; inc = 1'b0;
        @(negedge clk);
        #1 check("done_one_cycle", 32'(out_done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; r_start = 1'b0; r_abort = 1'b0; src_valid = 1'b0; ack = 1'b0;
        stall = 1'b0; inc = 1'b0; fend = 1'b0; r_width = 11'd0; r_height = 11'd0;
        src_pixel = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_error", 32'(out_error), 32'd0);
        check("rst_cc", 32'(out_cc), 32'd0);
        check("rst_fc", 32'(out_fc), 32'd0);
        check("rst_xy", 32'({pipe_x, pipe_y}), 32'd0);
        check("rst_ready_valid_begin", 32'({src_ready, pipe_valid, begin_rst}), 32'd0);
        reset = 1'b0;

        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        #1 check("idle_inc_ignored", 32'(out_cc), 32'd0);

        run_frame(40, 40, 1'b1, 0, 5, 20, -1);

        @(negedge clk); r_width = 11'd36; r_height = 11'd40; r_start = 1'b1;
        @(negedge clk); r_start = 1'b0;
        #1;
        check("bad_dim_error", 32'(out_error), 32'd1);
        check("bad_dim_busy", 32'(out_busy), 32'd0);
        check("bad_dim_no_begin", 32'(begin_rst), 32'd0);
        check("bad_dim_cc_hold", 32'(out_cc), 32'(exp_cc));

        run_frame(40, 40, 1'b0, 1, 9, 10, -1);
        run_frame(40, 40, 1'b1, 0, 2, 0, 20 * 40 + 10);

        @(negedge clk); r_width = 11'd40; r_height = 11'd40; r_start = 1'b1; r_abort = 1'b1;
        @(negedge clk); r_start = 1'b0; r_abort = 1'b0;
        #1;
        check("start_abort_idle", 32'(out_busy), 32'd0);
        check("start_abort_no_begin", 32'(begin_rst), 32'd0);
        check("start_abort_cc_hold", 32'(out_cc), 32'(exp_cc));

        run_frame(37, 37, 1'b1, 0, 0, -1, -1);

        @(negedge clk); r_width = 11'd37; r_height = 11'd37; r_start = 1'b1;
        @(negedge clk); r_start = 1'b0; ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ack = 1'b0; src_valid = 1'b1; stall = 1'b0; inc = 1'b1;
            src_pixel = 8'($urandom);
            #1 push_px(src_pixel, i, 37);
        end
        @(negedge clk); src_valid = 1'b0; inc = 1'b0; reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_busy", 32'(out_busy), 32'd0);
        check("midrst_cc", 32'(out_cc), 32'd0);
        check("midrst_fc", 32'(out_fc), 32'd0);
        check("midrst_error", 32'(out_error), 32'd0);
        check("midrst_xy", 32'({pipe_x, pipe_y}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("pixels_outstanding", 32'(exp_px.size()), 32'd0);
        check("done_outstanding", 32'(exp_done.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
